// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for the shared shift unit: runs a short opcode program on one operand.
// Optional macro SHIFT_SEQ_EARLY_EXIT_EN stops the program as soon as the shift result is zero.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_OPS = 4,
  localparam int unsigned CntW   = $clog2(MAX_OPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     op_data,
  input  logic [2*MAX_OPS-1:0] prog,
  input  logic [CntW-1:0]      num_ops,
  output logic [WIDTH-1:0]     sh_in,
  output logic [1:0]           sh_sel,
  input  logic [WIDTH-1:0]     sh_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic [CntW-1:0]      ops_done,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q;
  logic [2*MAX_OPS-1:0] prog_q;
  logic [CntW-1:0]      n_q;
  logic [CntW-1:0]      idx_q;

  logic [CntW-1:0]      n_clamp;
  logic [CntW-1:0]      idx_next;
  logic [2*MAX_OPS-1:0] prog_shift;
  logic [1:0]           cur_op;
  logic                 last_op;
  logic                 early_zero;

  assign n_clamp    = (num_ops > CntW'(MAX_OPS)) ? CntW'(MAX_OPS) : num_ops;
  assign idx_next   = idx_q + CntW'(1);
  assign prog_shift = prog_q >> {idx_q, 1'b0};
  assign cur_op     = prog_shift[1:0];
  assign last_op    = (idx_next == n_q);

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  assign early_zero = (sh_out == '0);
`else
  assign early_zero = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_valid) begin
          state_d = (n_clamp != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (last_op || early_zero) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: command capture in IDLE, one opcode applied per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      prog_q <= '0;
      n_q    <= '0;
      idx_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_valid) begin
            acc_q  <= op_data;
            prog_q <= prog;
            n_q    <= n_clamp;
            idx_q  <= '0;
          end
        end
        StRun: begin
          acc_q <= sh_out;
          idx_q <= idx_next;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    start_ready = 1'b0;
    res_valid   = 1'b0;
    sh_sel      = 2'b00;
    sh_in       = acc_q;
    res_data    = acc_q;
    ops_done    = idx_q;
    busy        = 1'b1;
    case (state_q)
      StIdle: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      StRun:   sh_sel    = cur_op;
      StDone:  res_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases plus randomized programs vs. a reference model.
// Honors SHIFT_SEQ_EARLY_EXIT_EN the same way as the design.
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [3:0] op_data = '0;
  logic [7:0] prog = '0;
  logic [2:0] num_ops = '0;
  logic [3:0] sh_in;
  logic [1:0] sh_sel;
  logic [3:0] sh_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic [2:0] ops_done;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [1:0] sel_log[$];
  logic [3:0] in_log[$];

  always #5 clk = ~clk;

  // Combinational shift unit stand-in
  always_comb begin
    case (sh_sel)
      2'b00:   sh_out = {sh_in[2:0], 1'b0};
      2'b01:   sh_out = {1'b0, sh_in[3:1]};
      2'b10:   sh_out = {sh_in[2:0], sh_in[3]};
      default: sh_out = {sh_in[0], sh_in[3:1]};
    endcase
  end

  shift_seq_ctrl #(.WIDTH(4), .MAX_OPS(4)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .op_data(op_data), .prog(prog), .num_ops(num_ops), .sh_in(sh_in), .sh_sel(sh_sel),
    .sh_out(sh_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .ops_done(ops_done), .busy(busy)
  );

  // Reference: apply each opcode arithmetically to the operand
  function automatic void ref_run(input int op, input int pg, input int num,
                                  output int res, output int cnt);
    int n;
    int a;
    n = (num > 4) ? 4 : num;
    a = op;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      case ((pg >> (2 * k)) % 4)
        0:       a = (a * 2) % 16;
        1:       a = a / 2;
        2:       a = (a * 2) % 16 + a / 8;
        default: a = a / 2 + (a % 2) * 8;
      endcase
      cnt++;
      if (Early && a == 0) break;
    end
    res = a;
  endfunction

  // Issue one command, hold off the result for 'hold' cycles, then complete the handshake.
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] pg, input logic [2:0] num,
                         input int hold, output int lat, output logic [3:0] res,
                         output logic [2:0] cnt, output bit stable, output bit sr_after,
                         output bit timeout);
    int guard;
    sel_log.delete();
    in_log.delete();
    timeout = 1'b0;
    stable = 1'b1;
    sr_after = 1'b0;
    lat = 0;
    res = 'x;
    cnt = 'x;
    @(negedge clk);
    start_valid = 1'b1;
    op_data = op;
    prog = pg;
    num_ops = num;
    guard = 0;
    while (start_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op_data = 4'($urandom);
    prog = 8'($urandom);
    num_ops = 3'($urandom);
    while (1) begin
      @(negedge clk);
      lat++;
      if (res_valid === 1'b1) break;
      if (busy === 1'b1) begin
        sel_log.push_back(sh_sel);
        in_log.push_back(sh_in);
      end
      if (lat > 20) begin
        timeout = 1'b1;
        return;
      end
    end
    res = res_data;
    cnt = ops_done;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!(res_valid === 1'b1 && res_data === res && start_ready === 1'b0)) stable = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    sr_after = (start_ready === 1'b1) && (res_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({start_ready, res_valid, res_data, sh_in, sh_sel, ops_done, busy} !== {1'b1, 1'b0, 4'h0,
        4'h0, 2'b00, 3'd0, 1'b0}) begin
      $display("FAIL reset_outputs: got sr=%b rv=%b rd=%h in=%h sel=%b od=%0d busy=%b, need 1 0 0 0 00 0 0",
               start_ready, res_valid, res_data, sh_in, sh_sel, ops_done, busy);
    end else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_full_program();
    int lat;
    logic [3:0] res;
    logic [2:0] cnt;
    bit st, sr, to;
    logic [1:0] exp_sel[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0] exp_in[4] = '{4'b0110, 4'b1100, 4'b0110, 4'b1100};
    run_cmd(4'b0110, 8'b11_10_01_00, 3'd4, 0, lat, res, cnt, st, sr, to);
    total_cnt++;
    if (to || lat !== 5) $display("FAIL full_latency: got %0d (timeout=%0b), need 5", lat, to);
    else pass_cnt++;
    total_cnt++;
    if (res !== 4'b0110) $display("FAIL full_result: got %b, need 0110", res);
    else pass_cnt++;
    total_cnt++;
    if (cnt !== 3'd4) $display("FAIL full_ops_done: got %0d, need 4", cnt);
    else pass_cnt++;
    total_cnt++;
    if (sel_log.size() != 4) $display("FAIL full_run_cycles: got %0d, need 4", sel_log.size());
    else pass_cnt++;
    for (int k = 0; k < 4 && k < sel_log.size(); k++) begin
      total_cnt++;
      if (sel_log[k] !== exp_sel[k] || in_log[k] !== exp_in[k])
        $display("FAIL full_step%0d: got sel=%b in=%b, need sel=%b in=%b",
                 k, sel_log[k], in_log[k], exp_sel[k], exp_in[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (!sr) $display("FAIL full_start_ready_after: got 0, need 1");
    else pass_cnt++;
  endtask

  task automatic test_partial_program();
    int lat;
    logic [3:0] res;
    logic [2:0] cnt;
    bit st, sr, to;
    run_cmd(4'b1001, {4'($urandom), 2'b00, 2'b10}, 3'd2, 0, lat, res, cnt, st, sr, to);
    total_cnt++;
    if (to || lat !== 3 || res !== 4'b0110 || cnt !== 3'd2)
      $display("FAIL partial_two_ops: got lat=%0d res=%b ops=%0d, need lat=3 res=0110 ops=2",
               lat, res, cnt);
    else pass_cnt++;
    run_cmd(4'b1001, 8'($urandom), 3'd0, 0, lat, res, cnt, st, sr, to);
    total_cnt++;
    if (to || lat !== 1 || res !== 4'b1001 || cnt !== 3'd0)
      $display("FAIL partial_zero_ops: got lat=%0d res=%b ops=%0d, need lat=1 res=1001 ops=0",
               lat, res, cnt);
    else pass_cnt++;
    total_cnt++;
    if (sel_log.size() != 0) $display("FAIL zero_ops_run_cycles: got %0d, need 0", sel_log.size());
    else pass_cnt++;
  endtask

  task automatic test_clamp_backpressure();
    int lat;
    logic [3:0] res;
    logic [2:0] cnt;
    bit st, sr, to;
    run_cmd(4'b0110, 8'b11_10_01_00, 3'd7, 3, lat, res, cnt, st, sr, to);
    total_cnt++;
    if (to || lat !== 5 || res !== 4'b0110 || cnt !== 3'd4)
      $display("FAIL clamp_result: got lat=%0d res=%b ops=%0d, need lat=5 res=0110 ops=4",
               lat, res, cnt);
    else pass_cnt++;
    total_cnt++;
    if (!st) $display("FAIL backpressure_stable: got unstable, need stable with start_ready low");
    else pass_cnt++;
    total_cnt++;
    if (!sr) $display("FAIL backpressure_start_ready: got 0 after handshake, need 1");
    else pass_cnt++;
  endtask

  task automatic test_early_exit();
    int lat;
    logic [3:0] res;
    logic [2:0] cnt;
    bit st, sr, to;
    int eres, ecnt;
    ref_run(1, 8'b00_00_00_01, 3, eres, ecnt);
    run_cmd(4'b0001, 8'b00_00_00_01, 3'd3, 0, lat, res, cnt, st, sr, to);
    total_cnt++;
    if (to || lat !== ecnt + 1 || res !== 4'(eres) || cnt !== 3'(ecnt))
      $display("FAIL early_exit: got lat=%0d res=%b ops=%0d, need lat=%0d res=%b ops=%0d",
               lat, res, cnt, ecnt + 1, 4'(eres), ecnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [3:0] res;
    logic [2:0] cnt;
    bit st, sr, to;
    bit saw_valid;
    int eres, ecnt;
    logic [3:0] op;
    logic [7:0] pg;
    @(negedge clk);
    start_valid = 1'b1;
    op_data = 4'b0110;
    prog = 8'b11_10_01_00;
    num_ops = 3'd4;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({start_ready, res_valid, res_data, sh_in, sh_sel, ops_done, busy} !== {1'b1, 1'b0, 4'h0,
        4'h0, 2'b00, 3'd0, 1'b0}) begin
      $display("FAIL midrun_reset_outputs: got sr=%b rv=%b rd=%h in=%h sel=%b od=%0d busy=%b, need 1 0 0 0 00 0 0",
               start_ready, res_valid, res_data, sh_in, sh_sel, ops_done, busy);
    end else pass_cnt++;
    saw_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid !== 1'b0) saw_valid = 1'b1;
    end
    total_cnt++;
    if (saw_valid) $display("FAIL midrun_no_result: got res_valid pulse, need none");
    else pass_cnt++;
    op = 4'($urandom);
    pg = 8'($urandom);
    ref_run(op, pg, 4, eres, ecnt);
    run_cmd(op, pg, 3'd4, 1, lat, res, cnt, st, sr, to);
    total_cnt++;
    if (to || res !== 4'(eres) || cnt !== 3'(ecnt) || lat !== ecnt + 1)
      $display("FAIL midrun_recover: got lat=%0d res=%b ops=%0d, need lat=%0d res=%b ops=%0d",
               lat, res, cnt, ecnt + 1, 4'(eres), ecnt);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat;
    logic [3:0] res;
    logic [2:0] cnt;
    bit st, sr, to;
    int eres, ecnt;
    logic [3:0] op;
    logic [7:0] pg;
    logic [2:0] num;
    int hold;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom);
      pg = 8'($urandom);
      num = 3'($urandom);
      hold = $urandom_range(0, 3);
      ref_run(op, pg, num, eres, ecnt);
      run_cmd(op, pg, num, hold, lat, res, cnt, st, sr, to);
      total_cnt++;
      if (to || res !== 4'(eres) || cnt !== 3'(ecnt) || lat !== ecnt + 1 || !st || !sr)
        $display("FAIL random_%0d: op=%b prog=%b n=%0d got lat=%0d res=%b ops=%0d st=%0b sr=%0b, need lat=%0d res=%b ops=%0d st=1 sr=1",
                 i, op, pg, num, lat, res, cnt, st, sr, ecnt + 1, 4'(eres), ecnt);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_full_program();
    test_partial_program();
    test_clamp_backpressure();
    test_early_exit();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the shared shift datapath (`Shift_Operators`, `in`/`sel`/`out`). It accepts an operand and a short program of shift opcodes through a valid/ready handshake. It then drives the shift unit one opcode per cycle, feeding each result back as the next input, and presents the final word on a valid/ready result port. It sits between a command source and the combinational shift unit, which it owns exclusively while busy.

## Interface
- `WIDTH`, 4, operand / shift-unit data width
- `MAX_OPS`, 4, maximum opcodes per program
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start_valid`  in  1  command present
- `start_ready`  out  1  controller can accept a command
- `op_data`  in  WIDTH  initial operand
- `prog`  in  2*MAX_OPS  opcodes; op k = `prog[2k+1:2k]`, op 0 executes first
- `num_ops`  in  $clog2(MAX_OPS+1)  opcodes to execute
- `sh_in`  out  WIDTH  to shift unit `in`
- `sh_sel`  out  2  to shift unit `sel`
- `sh_out`  in  WIDTH  from shift unit `out` (combinational, same cycle)
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  WIDTH  final word
- `ops_done`  out  $clog2(MAX_OPS+1)  opcodes actually executed for the current result
- `busy`  out  1  high in RUN or DONE

## Operation
- Shift unit opcode meaning: 00 = logical left by 1, 01 = logical right by 1, 10 = rotate left by 1, 11 = rotate right by 1.
- States: IDLE, RUN, DONE.
- IDLE
  - `start_ready` = 1.
  - When `start_valid` is high: latch `op_data` into the accumulator, latch `prog`, latch num_ops clamped to MAX_OPS, and clear the op index.
  - Next state is RUN if clamped num_ops > 0, else DONE.
- RUN
  - `sh_in` = acc, `sh_sel` = op[idx].
  - Each cycle: acc <= `sh_out`, idx <= idx+1.
  - After the op with idx == n−1 is applied, go to DONE.
- DONE
  - `res_valid` = 1 and `res_data` = acc, held stable until `res_ready`.
  - On `res_valid && res_ready`, go to IDLE.
- Outside RUN: `sh_sel` = 00 and `sh_in` = acc.
- `ops_done` = idx. It is updated in RUN and held through DONE.
- `start_ready` = 0 in RUN and DONE. Commands are neither queued nor dropped silently; the source must hold `start_valid`.
- num_ops > MAX_OPS is clamped to MAX_OPS. Extra `prog` bits are ignored.

## Timing
- Reset values: state = IDLE, acc = 0, idx = 0. Outputs: `start_ready` = 1, `res_valid` = 0, `res_data` = 0, `sh_in` = 0, `sh_sel` = 00, `ops_done` = 0, `busy` = 0.
- Command accepted at edge T. RUN covers cycles T+1 … T+n. `res_valid` rises in cycle T+n+1.
- Latency from accept to result is n+1 cycles. For n = 0 it is 1 cycle, and `res_data` = `op_data`.
- Result handshake completes at edge R. `start_ready` = 1 in cycle R+1. There is no same-cycle turnaround (no accept in DONE).
- `rst` in any state returns to IDLE at the next edge with reset values. The in-flight program is discarded and no result is produced.
- `prog`, `op_data` and `num_ops` are sampled only at accept; changes afterwards have no effect.

## Configuration
- `SHIFT_SEQ_EARLY_EXIT_EN` defined:
  - In RUN, if `sh_out` == 0, the controller writes acc and goes to DONE immediately, skipping the remaining ops.
  - `ops_done` reports the ops executed, including the one that produced zero.
- `SHIFT_SEQ_EARLY_EXIT_EN` undefined: all n ops always execute.

## Test plan
- Full program:
  - Stimulus: `op_data`=0110, `prog`=11_10_01_00, `num_ops`=4.
  - `sh_sel` sequence: 00, 01, 10, 11.
  - acc sequence: 1100, 0110, 1100, 0110.
  - Result: `res_data`=0110, `ops_done`=4, `res_valid` 5 cycles after accept.
- Partial program:
  - Stimulus: `op_data`=1001, op0=10, op1=00, `num_ops`=2.
  - Result: `res_data`=0110, `ops_done`=2, latency 3. `num_ops`=0 with the same operand gives `res_data`=1001 after 1 cycle.
- Clamp and backpressure:
  - Stimulus: `num_ops`=7 with the program of the first case.
  - Only 4 ops execute. `res_valid`/`res_data` stay stable while `res_ready`=0 for 3 cycles. `start_ready` stays low until 1 cycle after the handshake.
- Early exit:
  - Stimulus: `op_data`=0001, ops 01, 00, 00, `num_ops`=3.
  - With the macro defined: `res_data`=0000, `ops_done`=1, latency 2.
  - Without the macro: `res_data`=0000, `ops_done`=3, latency 4.
- Reset mid-run:
  - Stimulus: assert `rst` for 1 cycle in the 2nd RUN cycle.
  - Next cycle: all outputs are at reset values and `start_ready`=1. No `res_valid` pulse follows. A new command then completes normally.
